piso_shifter: RTL

- Parallel-in serial-out shift stage that sits directly downstream of the 4-bit parallel register (PIPO) and consumes its q word.
- Accepts one WIDTH-bit word per valid/ready handshake and emits it one bit per enabled clock on a serial line, with frame-start and valid markers.
- Serves as the serialising back end of the Digital_circuits register chain.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_shifter_if.sv | 39 +++
 rtl/piso_bit_counter.sv | 34 +++
 rtl/piso_shifter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and sizing helper for the piso_shifter
// serialiser and its bit counter.
package piso_pkg;

    // Serialiser states. PAR is only ever entered when the block is built
    // with PISO_PARITY_EN defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Width of a counter that has to reach width-1. A 2-bit word still
    // needs one counter bit, so the result never drops below 1.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shifter_if.sv
// piso_shifter_if: parallel load handshake plus serial output bundle of the
// piso_shifter. The master side is the upstream register / consumer pair,
// the slave side is the serialiser itself.
interface piso_shifter_if #(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] a;           // parallel word from the upstream register
    logic             load_valid;  // upstream presents a word on a
    logic             load_ready;  // serialiser accepts a word this cycle
    logic             en;          // shift enable, low stalls the serialiser
    logic             sout;        // serial data bit
    logic             sout_valid;  // sout carries a frame bit
    logic             sof;         // sout carries the first bit of a frame
    logic             busy;        // a frame is in progress

    modport master (
        output a,
        output load_valid,
        output en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  sof,
        input  busy
    );

    modport slave (
        input  a,
        input  load_valid,
        input  en,
        output load_ready,
        output sout,
        output sout_valid,
        output sof,
        output busy
    );

endinterface

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable, enable-gated up-counter with a terminal-count
// flag. Tracks which data bit of the frame is currently on the serial line.
module piso_bit_counter #(
    parameter int CNT_W  = 2,
    parameter int TC_VAL = 3
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active low
    input  logic             load,      // synchronous load, wins over inc
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,       // count up by one
    output logic             tc         // counter sits at TC_VAL
);

    localparam logic [CNT_W-1:0] TC = TC_VAL[CNT_W-1:0];

    logic [CNT_W-1:0] cnt;

    // Count register: load has priority, otherwise step when enabled.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block evaluation order.
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TC);

endmodule

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in serial-out stage behind the 4-bit PIPO register.
// Takes one WIDTH-bit word per load_valid/load_ready handshake and plays it
// out one bit per enabled clock on sout, with sout_valid and a one-bit sof
// marker. Frames can follow each other with no gap: the word for the next
// frame is accepted on the edge that retires the current frame's last bit.
//
// Build option: define PISO_PARITY_EN to append one even-parity bit (XOR of
// the captured word) after the data bits, making frames WIDTH+1 bits long.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,     // bits per word, 2..32
    parameter bit MSB_FIRST = 1'b1   // 1: a[WIDTH-1] first, 0: a[0] first
) (
    input logic           clk,
    input logic           rst,       // asynchronous, active low
    piso_shifter_if.slave bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;        // data bits still to be shown on sout
    logic             sout_q;
    logic             sout_valid_q;
    logic             sof_q;

    logic             accept;        // capture bus.a on this edge
    logic             advance;       // move to the next data bit
    logic             drain;         // frame ends with no follow-on word
    logic             ready_c;       // word could be accepted this edge
    logic             last;          // last data bit is on sout

    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] sreg_load;
    logic [WIDTH-1:0] sreg_shift;

`ifdef PISO_PARITY_EN
    logic             go_par;        // data done, parity bit goes out next
    logic             par_q;         // parity of the captured word
`endif

    // Bit selection depends only on the static bit order. On load the first
    // bit goes straight to sout, so the shift register keeps the rest,
    // already shifted by one position.
    assign first_bit  = MSB_FIRST ? bus.a[WIDTH-1]  : bus.a[0];
    assign next_bit   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sreg_load  = MSB_FIRST ? (bus.a << 1)    : (bus.a >> 1);
    assign sreg_shift = MSB_FIRST ? (sreg_q << 1)   : (sreg_q >> 1);

    // Index of the data bit on sout; restarts at 0 with every accepted word.
    piso_bit_counter #(
        .CNT_W  (CNT_W),
        .TC_VAL (WIDTH - 1)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ('0),
        .inc      (advance),
        .tc       (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the datapath action for the coming edge. en only gates
    // progress inside a frame; loading from IDLE never waits for it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        drain   = 1'b0;
        ready_c = 1'b0;
`ifdef PISO_PARITY_EN
        go_par  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.load_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    if (!last) begin
                        advance = 1'b1;
                    end else begin
`ifdef PISO_PARITY_EN
                        go_par  = 1'b1;
                        state_d = PAR;
`else
                        // Last data bit retires: take a waiting word now so
                        // its first bit follows without a gap.
                        ready_c = 1'b1;
                        if (bus.load_valid) begin
                            accept  = 1'b1;
                            state_d = SHIFT;
                        end else begin
                            drain   = 1'b1;
                            state_d = IDLE;
                        end
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                // Parity bit retires: same back-to-back rule as above.
                if (bus.en) begin
                    ready_c = 1'b1;
                    if (bus.load_valid) begin
                        accept  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        drain   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift register and registered serial outputs. With no action selected
    // (stall, or idle without a load) everything simply holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q       <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
        end else if (accept) begin
            sreg_q       <= sreg_load;
            sout_q       <= first_bit;
            sout_valid_q <= 1'b1;
            sof_q        <= 1'b1;
        end else if (advance) begin
            sreg_q       <= sreg_shift;
            sout_q       <= next_bit;
            sof_q        <= 1'b0;
`ifdef PISO_PARITY_EN
        end else if (go_par) begin
            sout_q       <= par_q;
            sof_q        <= 1'b0;
`endif
        end else if (drain) begin
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
        end
    end

`ifdef PISO_PARITY_EN
    // Even parity of the word, fixed at capture time so the shifting data
    // does not disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^bus.a;
        end
    end
`endif

    // load_ready is held low throughout reset even though the state
    // register already reads IDLE.
    assign bus.load_ready = rst & ready_c;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.sof        = sof_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
